kernel_weight_loader: RTL and testbench



---
 rtl/kernel_cfg_pkg.sv | 37 +++
 rtl/kernel_weight_loader_if.sv | 29 ++
 rtl/weight_packer.sv | 48 ++++
 rtl/kernel_weight_loader.sv | 113 +++++++++++
 tb/tb_kernel_weight_loader.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/kernel_cfg_pkg.sv
// rtl/kernel_cfg_pkg.sv - shared kernel geometry helpers and loader state encoding
package kernel_cfg_pkg;

    localparam int DEF_BITS_PER_KERNEL_WEIGHT = 6;
    localparam int DEF_KERNEL_SIZE            = 3;
    localparam int DEF_IN_CHANNELS            = 1;
    localparam int DEF_OUT_CHANNELS           = 4;

    function automatic int calc_data_width(input int bits, input int out_ch);
        return bits * out_ch;
    endfunction

    function automatic int calc_total_positions(input int in_ch, input int ksize);
        return in_ch * ksize * ksize;
    endfunction

    // A single-word kernel still needs a 1-bit address bus
    function automatic int calc_addr_width(input int total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

    function automatic int calc_chan_width(input int out_ch);
        return (out_ch > 1) ? $clog2(out_ch) : 1;
    endfunction

    localparam int DEF_DATA_WIDTH = calc_data_width(DEF_BITS_PER_KERNEL_WEIGHT, DEF_OUT_CHANNELS);
    localparam int DEF_TOTAL_KERNEL_POSITIONS = calc_total_positions(DEF_IN_CHANNELS, DEF_KERNEL_SIZE);
    localparam int DEF_ADDR_WIDTH = calc_addr_width(DEF_TOTAL_KERNEL_POSITIONS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } loader_state_e;

endpackage

// File: rtl/kernel_weight_loader_if.sv
// rtl/kernel_weight_loader_if.sv - weight stream, control and BRAM write port bundle
interface kernel_weight_loader_if
    import kernel_cfg_pkg::*;
#(
    parameter int BW = DEF_BITS_PER_KERNEL_WEIGHT,
    parameter int AW = DEF_ADDR_WIDTH,
    parameter int DW = DEF_DATA_WIDTH
);
    logic          start;
    logic [BW-1:0] s_weight;
    logic          s_valid;
    logic          s_ready;
    logic          bram_en;
    logic          bram_we;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_data_in;
    logic          busy;
    logic          done;

    modport master (
        output start, s_weight, s_valid,
        input  s_ready, bram_en, bram_we, bram_addr, bram_data_in, busy, done
    );

    modport slave (
        input  start, s_weight, s_valid,
        output s_ready, bram_en, bram_we, bram_addr, bram_data_in, busy, done
    );
endinterface

// File: rtl/weight_packer.sv
// rtl/weight_packer.sv - packs OC consecutive weights into one word, channel 0 in the low bits
module weight_packer
    import kernel_cfg_pkg::*;
#(
    parameter int B  = DEF_BITS_PER_KERNEL_WEIGHT,
    parameter int OC = DEF_OUT_CHANNELS
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            beat,
    input  logic [B-1:0]    weight,
    output logic            word_valid,
    output logic [B*OC-1:0] word
);
    localparam int CW = calc_chan_width(OC);
    localparam logic [CW-1:0] LAST_CH = CW'(OC - 1);

    logic [CW-1:0]   ch_q, ch_d;
    logic [B*OC-1:0] pack_q, pack_d;

    always_comb begin
        ch_d       = ch_q;
        pack_d     = pack_q;
        word_valid = 1'b0;
        if (clear) begin
            ch_d   = '0;
            pack_d = '0;
        end else if (beat) begin
            pack_d[int'(ch_q)*B +: B] = weight;
            word_valid = (ch_q == LAST_CH);
            ch_d       = word_valid ? '0 : ch_q + CW'(1);
        end
    end

    // The completed word is handed out in the same cycle as its last beat
    assign word = pack_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_q   <= '0;
            pack_q <= '0;
        end else begin
            ch_q   <= ch_d;
            pack_q <= pack_d;
        end
    end
endmodule

// File: rtl/kernel_weight_loader.sv
// rtl/kernel_weight_loader.sv - streams kernel weights into the weight BRAM, one packed word per address
module kernel_weight_loader
    import kernel_cfg_pkg::*;
#(
    parameter int BITS_PER_KERNEL_WEIGHT = DEF_BITS_PER_KERNEL_WEIGHT,
    parameter int KERNEL_SIZE            = DEF_KERNEL_SIZE,
    parameter int IN_CHANNELS            = DEF_IN_CHANNELS,
    parameter int OUT_CHANNELS           = DEF_OUT_CHANNELS,
    parameter int DATA_WIDTH             = calc_data_width(BITS_PER_KERNEL_WEIGHT, OUT_CHANNELS),
    parameter int TOTAL_KERNEL_POSITIONS = calc_total_positions(IN_CHANNELS, KERNEL_SIZE),
    parameter int ADDR_WIDTH             = calc_addr_width(TOTAL_KERNEL_POSITIONS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    kernel_weight_loader_if.slave  bus
);
    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_LOAD  = ST_LOAD;
    localparam logic [1:0] S_FLUSH = ST_FLUSH;
    localparam logic [1:0] S_DONE  = ST_DONE;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(TOTAL_KERNEL_POSITIONS - 1);

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_cnt_q, addr_cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  en_q, en_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  s_ready;
    logic                  clear;
    logic                  word_valid;
    logic [DATA_WIDTH-1:0] word;

    assign s_ready = (state_q == S_LOAD);

    weight_packer #(
        .B  (BITS_PER_KERNEL_WEIGHT),
        .OC (OUT_CHANNELS)
    ) u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .beat       (bus.s_valid && s_ready),
        .weight     (bus.s_weight),
        .word_valid (word_valid),
        .word       (word)
    );

    always_comb begin
        state_d    = state_q;
        addr_cnt_d = addr_cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        en_d       = 1'b0;
        clear      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d    = S_LOAD;
                    addr_cnt_d = '0;
                    clear      = 1'b1;
                end
            end
            S_LOAD: begin
                if (word_valid) begin
                    en_d   = 1'b1;
                    addr_d = addr_cnt_q;
                    data_d = word;
                    if (addr_cnt_q < LAST_ADDR) begin
                        addr_cnt_d = addr_cnt_q + ADDR_WIDTH'(1);
                    end else begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
        // Status flags are registered from the next state so they line up with it
        busy_d = (state_d == S_LOAD) || (state_d == S_FLUSH);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_cnt_q <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            en_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_cnt_q <= addr_cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            en_q       <= en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.s_ready      = s_ready;
    assign bus.bram_en      = en_q;
    assign bus.bram_we      = en_q;
    assign bus.bram_addr    = addr_q;
    assign bus.bram_data_in = data_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
endmodule

// File: tb/tb_kernel_weight_loader.sv
// tb/tb_kernel_weight_loader.sv - scoreboard bench for kernel_weight_loader
module tb_kernel_weight_loader;
    localparam int B  = 6;
    localparam int OC = 4;
    localparam int NW = 36;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   edge_cnt = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    wr_t         exp_wr[$];
    int          exp_done[$];
    logic [31:0] seen_data[16];
    logic [B-1:0] w[NW];

    kernel_weight_loader_if #(.BW(6), .AW(4), .DW(24)) bus ();
    kernel_weight_loader_if #(.BW(6), .AW(1), .DW(6))  bus2 ();

    kernel_weight_loader dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    kernel_weight_loader #(
        .OUT_CHANNELS(1), .KERNEL_SIZE(1), .IN_CHANNELS(2)
    ) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_s_ready"}, bus.s_ready, 0);
        chk({tag, "_bram_en"}, bus.bram_en, 0);
        chk({tag, "_bram_we"}, bus.bram_we, 0);
        chk({tag, "_bram_addr"}, bus.bram_addr, 0);
        chk({tag, "_bram_data_in"}, bus.bram_data_in, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
    endtask

    // Monitor: every write and done pulse must match the next scoreboard entry
    always @(negedge clk) begin
        wr_t e;
        int  d;
        if (bus.bram_en) begin
            seen_data[bus.bram_addr] = bus.bram_data_in;
            chk("write_expected", exp_wr.size() > 0, 1);
            if (exp_wr.size() > 0) begin
                e = exp_wr.pop_front();
                chk("wr_addr", bus.bram_addr, e.addr);
                chk("wr_data", bus.bram_data_in, e.data);
                chk("wr_cycle", edge_cnt, e.cyc);
            end
            chk("wr_we", bus.bram_we, 1);
            chk("wr_busy", bus.busy, 1);
        end
        if (bus.done) begin
            chk("done_expected", exp_done.size() > 0, 1);
            if (exp_done.size() > 0) begin
                d = exp_done.pop_front();
                chk("done_cycle", edge_cnt, d);
            end
            chk("done_busy", bus.busy, 0);
        end
    end

    // mode 0: valid always, 1: valid toggles, 2: random valid plus stray starts, 3: stop after 10 beats
    task automatic run_load(input int mode);
        int          idx = 0;
        int          beat = 0;
        int          word = 0;
        int          guard = 0;
        int          start_edge;
        int          last_edge = 0;
        logic [23:0] acc = '0;
        logic        acc_now;
        logic        tog = 1'b1;
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        start_edge = edge_cnt;
        while (idx < NW && guard < 1000) begin
            if (mode == 3 && idx == 10) break;
            guard++;
            case (mode)
                1:       bus.s_valid = tog;
                2:       bus.s_valid = 1'($urandom_range(0, 1));
                default: bus.s_valid = 1'b1;
            endcase
            tog = ~tog;
            bus.s_weight = w[idx];
            if (mode == 2) bus.start = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc_now = bus.s_valid && bus.s_ready;
            @(posedge clk); #1;
            if (acc_now) begin
                acc[beat*B +: B] = w[idx];
                idx++;
                beat++;
                last_edge = edge_cnt;
                if (beat == OC) begin
                    exp_wr.push_back('{32'(word), 32'(acc), edge_cnt});
                    if (word == NW / OC - 1) exp_done.push_back(edge_cnt + 1);
                    word++;
                    beat = 0;
                end
            end
        end
        bus.s_valid = 1'b0;
        if (guard >= 1000) chk("load_progress", idx, NW);
        if (mode == 0) chk("full_rate_last_beat", last_edge - start_edge, NW);
        if (mode == 2) begin
            bus.start = 1'b1;
            @(posedge clk);
            @(posedge clk); #1 bus.start = 1'b0;
        end else begin
            bus.start = 1'b0;
        end
        if (mode != 3) repeat (4) @(posedge clk);
    endtask

    initial begin
        int n_en;
        bus.start = 0; bus.s_valid = 0; bus.s_weight = '0;
        bus2.start = 0; bus2.s_valid = 0; bus2.s_weight = '0;

        repeat (2) @(posedge clk);
        #1 chk_outputs_zero("reset");
        rst_n = 1'b1;
        n_en = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus.bram_en) n_en++;
        end
        chk("idle_no_write", n_en, 0);
        chk("idle_not_busy", bus.busy, 0);

        // Single-channel, two-position configuration
        @(posedge clk); #1 bus2.start = 1'b1;
        @(posedge clk); #1 bus2.start = 1'b0; bus2.s_valid = 1'b1; bus2.s_weight = 6'd5;
        @(posedge clk); #1 bus2.s_weight = 6'd9;
        chk("cfg2_wr0_en", bus2.bram_en, 1);
        chk("cfg2_wr0_addr", bus2.bram_addr, 0);
        chk("cfg2_wr0_data", bus2.bram_data_in, 5);
        @(posedge clk); #1 bus2.s_valid = 1'b0;
        chk("cfg2_wr1_en", bus2.bram_en, 1);
        chk("cfg2_wr1_addr", bus2.bram_addr, 1);
        chk("cfg2_wr1_data", bus2.bram_data_in, 9);
        chk("cfg2_wr1_done", bus2.done, 0);
        @(posedge clk); #1;
        chk("cfg2_post_en", bus2.bram_en, 0);
        chk("cfg2_done", bus2.done, 1);
        chk("cfg2_busy", bus2.busy, 0);
        @(posedge clk); #1;
        chk("cfg2_done_pulse", bus2.done, 0);

        for (int i = 0; i < NW; i++) w[i] = 6'(i % 64);
        run_load(0);
        chk("word0_value", seen_data[0], 32'h0C2040);
        chk("word1_value", seen_data[1], 32'h1C6144);
        run_load(1);

        for (int i = 0; i < NW; i++) w[i] = 6'($urandom_range(0, 63));
        run_load(2);
        for (int i = 0; i < NW; i++) w[i] = 6'($urandom_range(0, 63));
        run_load(0);

        for (int i = 0; i < NW; i++) w[i] = 6'($urandom_range(0, 63));
        run_load(3);
        #2 rst_n = 1'b0;
        #1 chk_outputs_zero("async_reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        n_en = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.bram_en) n_en++;
        end
        chk("no_partial_write", n_en, 0);

        for (int i = 0; i < NW; i++) w[i] = 6'd63;
        for (int a = 0; a < 16; a++) seen_data[a] = '0;
        run_load(0);
        for (int a = 0; a < NW / OC; a++) chk("all_ones_word", seen_data[a], 32'hFFFFFF);

        chk("writes_outstanding", exp_wr.size(), 0);
        chk("dones_outstanding", exp_done.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
